// File: rtl/order_packer.sv
// Packs a stream of host words into one wide accelerator order and pushes it into the order cache.
// Orders with an illegal opcode are dropped and flagged in a sticky error bit.
module order_packer #(
    parameter int DATA_W      = 32,
    parameter int ORDER_W     = 256,
    parameter int NUM_OPCODES = 5,
    parameter int CNT_W       = 16
) (
    input  logic               clk,
    input  logic               srst,
    input  logic               word_valid,
    input  logic [DATA_W-1:0]  word_data,
    output logic               word_ready,
    input  logic               abort,
    input  logic               order_in_ready,
    output logic               push_order_en,
    output logic [ORDER_W-1:0] order_data,
    output logic               busy,
    output logic               err_opcode,
    input  logic               err_clr,
    output logic [CNT_W-1:0]   push_cnt
);

    localparam int WORDS = ORDER_W / DATA_W;
    localparam int WC_W  = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic {
        COLLECT = 1'b0,
        PUSH    = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [WC_W-1:0]      word_cnt_q, word_cnt_d;
    logic [ORDER_W-1:0]   order_data_q, order_data_d;
    logic                 err_opcode_q, err_opcode_d;
    logic [CNT_W-1:0]     push_cnt_q, push_cnt_d;

    logic                 accept;
    logic                 last_word;
    logic [2:0]           opcode;
    logic                 opcode_ok;
    logic [WORDS-1:0]     lane_wr;

    assign word_ready    = ~srst & ~abort & (state_q == COLLECT);
    assign push_order_en = ~srst & ~abort & (state_q == PUSH) & order_in_ready;
    assign accept        = word_valid & word_ready;
    assign last_word     = (word_cnt_q == WC_W'(WORDS - 1));

    // The opcode lives in word 0; for a one-word order it is still on the input bus.
    assign opcode    = (word_cnt_q == '0) ? word_data[2:0] : order_data_q[2:0];
    assign opcode_ok = (32'(opcode) < NUM_OPCODES);

    generate
        for (genvar gi = 0; gi < WORDS; gi++) begin : g_lane
            assign lane_wr[gi] = accept & (word_cnt_q == WC_W'(gi));
            assign order_data_d[gi*DATA_W +: DATA_W] =
                lane_wr[gi] ? word_data : order_data_q[gi*DATA_W +: DATA_W];
        end
    endgenerate

    always_comb begin
        state_d      = state_q;
        word_cnt_d   = word_cnt_q;
        push_cnt_d   = push_cnt_q;
        err_opcode_d = err_opcode_q & ~err_clr;

        if (abort) begin
            state_d    = COLLECT;
            word_cnt_d = '0;
        end else begin
            case (state_q)
                COLLECT: begin
                    if (accept) begin
                        if (last_word) begin
                            word_cnt_d = '0;
                            if (opcode_ok) begin
                                state_d = PUSH;
                            end else begin
                                err_opcode_d = 1'b1;
                            end
                        end else begin
                            word_cnt_d = word_cnt_q + 1'b1;
                        end
                    end
                end
                PUSH: begin
                    if (push_order_en) begin
                        push_cnt_d = push_cnt_q + 1'b1;
                        word_cnt_d = '0;
                        state_d    = COLLECT;
                    end
                end
                default: begin
                    state_d    = COLLECT;
                    word_cnt_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            state_q      <= COLLECT;
            word_cnt_q   <= '0;
            order_data_q <= '0;
            err_opcode_q <= 1'b0;
            push_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            word_cnt_q   <= word_cnt_d;
            order_data_q <= order_data_d;
            err_opcode_q <= err_opcode_d;
            push_cnt_q   <= push_cnt_d;
        end
    end

    assign order_data = order_data_q;
    assign err_opcode = err_opcode_q;
    assign push_cnt   = push_cnt_q;
    assign busy       = (state_q != COLLECT) | (word_cnt_q != '0);

endmodule

// File: tb/tb_order_packer.sv
// Bench for order_packer: directed scenarios plus random traffic, all checked every cycle
// against a word-queue reference model.
module tb_order_packer;

    logic         clk = 1'b0;
    logic         srst;
    logic         word_valid;
    logic [31:0]  word_data;
    logic         word_ready;
    logic         abort;
    logic         order_in_ready;
    logic         push_order_en;
    logic [255:0] order_data;
    logic         busy;
    logic         err_opcode;
    logic         err_clr;
    logic [15:0]  push_cnt;

    always #5 clk = ~clk;

    order_packer #(
        .DATA_W(32), .ORDER_W(256), .NUM_OPCODES(5), .CNT_W(16)
    ) dut (
        .clk(clk), .srst(srst), .word_valid(word_valid), .word_data(word_data),
        .word_ready(word_ready), .abort(abort), .order_in_ready(order_in_ready),
        .push_order_en(push_order_en), .order_data(order_data), .busy(busy),
        .err_opcode(err_opcode), .err_clr(err_clr), .push_cnt(push_cnt)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: accepted words of the current order, plus a pending finished order.
    logic [31:0]  m_words[$];
    bit           m_pending;
    bit           m_err;
    logic [15:0]  m_push_cnt;
    logic [255:0] m_data;
    bit           m_known;
    bit           m_accept;

    int cyc = 0;
    int n_pushes = 0;
    int last_push_cyc = 0;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input bit v, input logic [31:0] d, input bit rdy,
                        input bit ab, input bit clr, input bit rst);
        bit exp_wr;
        bit exp_push;
        @(negedge clk);
        word_valid     = v;
        word_data      = d;
        order_in_ready = rdy;
        abort          = ab;
        err_clr        = clr;
        srst           = rst;
        #1;
        exp_wr   = !rst && !ab && !m_pending;
        exp_push = !rst && !ab && m_pending && rdy;
        check("word_ready", 256'(word_ready), 256'(exp_wr));
        check("push_en", 256'(push_order_en), 256'(exp_push));
        check("busy", 256'(busy), 256'(m_pending || m_words.size() != 0));
        check("err_opcode", 256'(err_opcode), 256'(m_err));
        check("push_cnt", 256'(push_cnt), 256'(m_push_cnt));
        if (m_known) check("order_data", order_data, m_data);
        if (push_order_en === 1'b1) begin
            n_pushes++;
            last_push_cyc = cyc;
            $display("push %0d at cycle %0d: %h", n_pushes, cyc, order_data);
        end
        m_accept = v && exp_wr;

        if (rst) begin
            m_words.delete();
            m_pending  = 1'b0;
            m_err      = 1'b0;
            m_push_cnt = '0;
            m_data     = '0;
            m_known    = 1'b1;
        end else begin
            if (clr) m_err = 1'b0;
            if (ab) begin
                m_words.delete();
                m_pending = 1'b0;
                m_known   = 1'b0;
            end else if (m_pending) begin
                if (rdy) begin
                    m_pending  = 1'b0;
                    m_push_cnt = m_push_cnt + 16'd1;
                end
            end else if (v) begin
                m_data[32*m_words.size() +: 32] = d;
                m_words.push_back(d);
                if (m_words.size() == 8) begin
                    m_known = 1'b1;
                    if (m_words[0][2:0] < 3'd5) m_pending = 1'b1;
                    else                        m_err     = 1'b1;
                    m_words.delete();
                end
            end
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] legal_w0();
        logic [31:0] w;
        w      = $urandom();
        w[2:0] = 3'($urandom_range(0, 4));
        return w;
    endfunction

    task automatic send_order(input logic [31:0] w0, input bit rdy);
        step(1'b1, w0, rdy, 1'b0, 1'b0, 1'b0);
        for (int k = 1; k < 8; k++) step(1'b1, $urandom(), rdy, 1'b0, 1'b0, 1'b0);
    endtask

    int           p0;
    int           w7_cyc;
    logic [15:0]  cnt0;
    logic [31:0]  t6_words[24];
    int           t6_pcs[$];
    int           idx;
    logic [63:0]  hi;

    initial begin
        srst = 1'b1; word_valid = 1'b0; word_data = '0; abort = 1'b0;
        order_in_ready = 1'b0; err_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        m_pending = 1'b0; m_err = 1'b0; m_push_cnt = '0; m_data = '0; m_known = 1'b1;
        check("rst_push_cnt", 256'(push_cnt), 256'(0));
        check("rst_busy", 256'(busy), 256'(0));
        check("rst_order_data", order_data, 256'(0));
        check("rst_word_ready", 256'(word_ready), 256'(0));

        // 1: minimal order, ready high, push the cycle after word 7
        step(1'b1, 32'h9, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int k = 1; k < 8; k++) begin
            w7_cyc = cyc;
            step(1'b1, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        end
        check("t1_opcode", 256'(order_data[2:0]), 256'(1));
        check("t1_base_addr", 256'(order_data[34:3]), 256'(1));
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("t1_push_cycle", 256'(last_push_cyc), 256'(w7_cyc + 1));
        check("t1_push_cnt", 256'(push_cnt), 256'(1));

        // 2: hold for 20 cycles with the cache not ready
        send_order(32'h9, 1'b0);
        p0 = n_pushes;
        repeat (20) step(1'b1, $urandom(), 1'b0, 1'b0, 1'b0, 1'b0);
        check("t2_no_push", 256'(n_pushes - p0), 256'(0));
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("t2_one_push", 256'(n_pushes - p0), 256'(1));

        // 3: illegal opcode dropped, sticky error, then cleared
        p0 = n_pushes;
        send_order(32'h7, 1'b1);
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("t3_no_push", 256'(n_pushes - p0), 256'(0));
        check("t3_err", 256'(err_opcode), 256'(1));
        send_order(legal_w0(), 1'b1);
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("t3_legal_push", 256'(n_pushes - p0), 256'(1));
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("t3_err_clr", 256'(err_opcode), 256'(0));

        // 4: abort mid-collect, then abort while pending
        p0 = n_pushes;
        for (int k = 0; k < 3; k++) step(1'b1, $urandom(), 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, $urandom(), 1'b1, 1'b1, 1'b0, 1'b0);
        send_order(legal_w0(), 1'b1);
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("t4_one_push", 256'(n_pushes - p0), 256'(1));
        cnt0 = push_cnt;
        send_order(legal_w0(), 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("t4_abort_push_cnt", 256'(push_cnt), 256'(cnt0));

        // 5: reset in the middle of an order
        for (int k = 0; k < 5; k++) step(1'b1, (k == 0) ? legal_w0() : $urandom(), 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, $urandom(), 1'b1, 1'b0, 1'b0, 1'b1);
        check("t5_push_cnt", 256'(push_cnt), 256'(0));
        check("t5_order_data", order_data, 256'(0));
        check("t5_busy", 256'(busy), 256'(0));
        p0 = n_pushes;
        send_order(legal_w0(), 1'b1);
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("t5_push", 256'(n_pushes - p0), 256'(1));

        // 6: three back-to-back orders with word_valid held high
        for (int k = 0; k < 24; k++) t6_words[k] = (k % 8 == 0) ? legal_w0() : $urandom();
        cnt0 = push_cnt;
        idx  = 0;
        for (int s = 0; s < 40 && t6_pcs.size() < 3; s++) begin
            p0 = n_pushes;
            step(idx < 24, t6_words[idx % 24], 1'b1, 1'b0, 1'b0, 1'b0);
            if (m_accept) idx++;
            if (n_pushes != p0) begin
                t6_pcs.push_back(last_push_cyc);
                hi = {t6_words[(t6_pcs.size()-1)*8 + 7], t6_words[(t6_pcs.size()-1)*8 + 6]};
                check("t6_id", 256'(order_data[232:201]), 256'(hi[40:9]));
            end
        end
        check("t6_count", 256'(t6_pcs.size()), 256'(3));
        check("t6_push_cnt", 256'(push_cnt - cnt0), 256'(3));
        if (t6_pcs.size() == 3) begin
            check("t6_gap1", 256'(t6_pcs[1] - t6_pcs[0]), 256'(9));
            check("t6_gap2", 256'(t6_pcs[2] - t6_pcs[1]), 256'(9));
        end

        // Random traffic
        for (int s = 0; s < 3000; s++) begin
            step($urandom_range(0, 9) < 7,
                 $urandom(),
                 $urandom_range(0, 9) < 6,
                 $urandom_range(0, 49) == 0,
                 $urandom_range(0, 19) == 0,
                 $urandom_range(0, 199) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
